// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one memory port between 2**CONTROL requesters using round-robin
// arbitration. One transaction is in flight at a time: the winner's request
// is latched, presented to memory over a valid/ready handshake, and the
// completion is routed back to the owning requester as a one-cycle strobe.

module mem_port_arbiter #(
    parameter int CONTROL    = 1,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 128
) (
    input  logic                      clk,
    input  logic                      rst_n,

    // requester side
    input  logic [(2**CONTROL)-1:0]   req_valid,
    input  logic [ADDR_WIDTH-1:0]     req_addr  [2**CONTROL],
    input  logic [(2**CONTROL)-1:0]   req_write,
    input  logic [DATA_WIDTH-1:0]     req_wdata [2**CONTROL],
    output logic [(2**CONTROL)-1:0]   req_ready,
    output logic [(2**CONTROL)-1:0]   resp_valid,
    output logic [DATA_WIDTH-1:0]     resp_data,

    // memory side
    output logic                      mem_req_valid,
    input  logic                      mem_req_ready,
    output logic [ADDR_WIDTH-1:0]     mem_req_addr,
    output logic                      mem_req_write,
    output logic [DATA_WIDTH-1:0]     mem_req_wdata,
    input  logic                      mem_resp_valid,
    input  logic [DATA_WIDTH-1:0]     mem_resp_data,

    // status
    output logic                      busy,
    output logic [CONTROL-1:0]        owner
);

    localparam int N = 2**CONTROL;

    // Transaction state encoding.
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;

    logic [1:0]         state;
    logic [CONTROL-1:0] last_grant;
    logic [CONTROL-1:0] grant_idx;
    logic               grant_found;
    logic               grant_fire;
    logic [N-1:0]       owner_onehot;

    // Round-robin search starting just after the last winner; the last
    // winner itself is examined last, so it has the lowest priority.
    always_comb begin
        // NOTE: every always_comb output gets a default before any branch so
        // no path leaves it unassigned, which would infer a latch.
        grant_found = 1'b0;
        grant_idx   = last_grant;
        for (int i = 1; i <= N; i++) begin
            logic [CONTROL-1:0] cand;
            cand = last_grant + CONTROL'(i);
            if (!grant_found && req_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    // A grant happens only while idle; the accept strobe is combinational so
    // the requester sees it in the same cycle it is sampled.
    assign grant_fire = (state == ST_IDLE) && grant_found;

    // One-hot accept strobe for the winner.
    always_comb begin
        req_ready = '0;
        if (grant_fire) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    // One-hot decode of the owning requester, used to steer the response.
    always_comb begin
        owner_onehot        = '0;
        owner_onehot[owner] = 1'b1;
    end

    assign mem_req_valid = (state == ST_ISSUE);
    assign busy          = (state != ST_IDLE);

    // Transaction sequencer and round-robin pointer.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (!rst_n) begin
            state      <= ST_IDLE;
            last_grant <= '1;
            owner      <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (grant_found) begin
                        state      <= ST_ISSUE;
                        last_grant <= grant_idx;
                        owner      <= grant_idx;
                    end
                end
                ST_ISSUE: begin
                    if (mem_req_ready) begin
                        state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (mem_resp_valid) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Capture the winner's request fields at grant time; they stay frozen
    // for the whole ISSUE state, so requesters may change req_* afterwards.
    always_ff @(posedge clk) begin
        // NOTE: these are plain datapath registers, not a memory array, so
        // they take a reset value and come up as zero rather than X.
        if (!rst_n) begin
            mem_req_addr  <= '0;
            mem_req_write <= 1'b0;
            mem_req_wdata <= '0;
        end else if (grant_fire) begin
            mem_req_addr  <= req_addr[grant_idx];
            mem_req_write <= req_write[grant_idx];
            mem_req_wdata <= req_wdata[grant_idx];
        end
    end

    // Completion: memory responses count only in WAIT; anything seen in IDLE
    // or ISSUE (including the handshake cycle) is ignored.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            resp_valid <= '0;
            resp_data  <= '0;
        end else begin
            resp_valid <= '0;
            if (state == ST_WAIT && mem_resp_valid) begin
                resp_valid <= owner_onehot;
                resp_data  <= mem_resp_data;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
// Directed bench for mem_port_arbiter (two requesters). Inputs change 1 time
// unit after the rising edge; outputs are sampled on the falling edge.

module tb_mem_port_arbiter;

    localparam int CONTROL    = 1;
    localparam int N          = 2;
    localparam int ADDR_WIDTH = 32;
    localparam int DATA_WIDTH = 128;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic [N-1:0]          req_valid;
    logic [ADDR_WIDTH-1:0] req_addr  [N];
    logic [N-1:0]          req_write;
    logic [DATA_WIDTH-1:0] req_wdata [N];
    logic [N-1:0]          req_ready;
    logic [N-1:0]          resp_valid;
    logic [DATA_WIDTH-1:0] resp_data;
    logic                  mem_req_valid;
    logic                  mem_req_ready;
    logic [ADDR_WIDTH-1:0] mem_req_addr;
    logic                  mem_req_write;
    logic [DATA_WIDTH-1:0] mem_req_wdata;
    logic                  mem_resp_valid;
    logic [DATA_WIDTH-1:0] mem_resp_data;
    logic                  busy;
    logic [CONTROL-1:0]    owner;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [DATA_WIDTH-1:0] DATA_DEAD = 128'hDEADBEEF_DEADBEEF_DEADBEEF_DEADBEEF;
    localparam logic [DATA_WIDTH-1:0] DATA_55   = 128'h55555555_55555555_55555555_55555555;
    localparam logic [DATA_WIDTH-1:0] DATA_CAFE = 128'hCAFEF00D_00000000_00000000_12345678;
    localparam logic [DATA_WIDTH-1:0] DATA_ACK  = 128'h0000F00D_0000F00D_0000F00D_0000F00D;
    localparam logic [DATA_WIDTH-1:0] DATA_77   = 128'h77;

    mem_port_arbiter #(
        .CONTROL    (CONTROL),
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_valid      (req_valid),
        .req_addr       (req_addr),
        .req_write      (req_write),
        .req_wdata      (req_wdata),
        .req_ready      (req_ready),
        .resp_valid     (resp_valid),
        .resp_data      (resp_data),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_addr   (mem_req_addr),
        .mem_req_write  (mem_req_write),
        .mem_req_wdata  (mem_req_wdata),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_data  (mem_resp_data),
        .busy           (busy),
        .owner          (owner)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive_edge;
        @(posedge clk);
        #1;
    endtask

    task automatic sample;
        @(negedge clk);
    endtask

    logic [N-1:0] exp_ready;
    logic [N-1:0] exp_resp;

    initial begin
        rst_n          = 1'b0;
        req_valid      = '0;
        req_write      = '0;
        req_addr[0]    = '0;
        req_addr[1]    = '0;
        req_wdata[0]   = '0;
        req_wdata[1]   = '0;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        mem_resp_data  = '0;

        // ---------------- reset values
        drive_edge;
        drive_edge;
        sample;
        check("rst_busy", busy, 1'b0);
        check("rst_resp_valid", resp_valid, 2'b00);
        check("rst_owner", owner, 1'b0);
        check("rst_mem_req_valid", mem_req_valid, 1'b0);
        check("rst_mem_req_addr", mem_req_addr, 32'h0);
        check("rst_req_ready", req_ready, 2'b00);

        // ---------------- single read, zero-wait memory
        drive_edge;
        rst_n         = 1'b1;
        req_valid     = 2'b01;
        req_addr[0]   = 32'h100;
        mem_req_ready = 1'b1;
        sample;
        check("rd_req_ready_t", req_ready, 2'b01);
        check("rd_busy_t", busy, 1'b0);

        drive_edge;
        req_valid = 2'b00;
        sample;
        check("rd_mem_req_valid_t1", mem_req_valid, 1'b1);
        check("rd_mem_req_addr_t1", mem_req_addr, 32'h100);
        check("rd_mem_req_write_t1", mem_req_write, 1'b0);
        check("rd_owner_t1", owner, 1'b0);

        drive_edge;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b1;
        mem_resp_data  = DATA_DEAD;
        sample;
        check("rd_mem_req_valid_t2", mem_req_valid, 1'b0);
        check("rd_busy_t2", busy, 1'b1);
        check("rd_resp_valid_t2", resp_valid, 2'b00);

        drive_edge;
        mem_resp_valid = 1'b0;
        sample;
        check("rd_resp_valid_t3", resp_valid, 2'b01);
        check("rd_resp_data_t3", resp_data, DATA_DEAD);
        check("rd_busy_t3", busy, 1'b0);

        drive_edge;
        sample;
        check("rd_resp_valid_t4", resp_valid, 2'b00);

        // ---------------- contention: both request continuously after reset
        drive_edge;
        rst_n = 1'b0;
        drive_edge;
        rst_n          = 1'b1;
        req_valid      = 2'b11;
        mem_req_ready  = 1'b1;
        mem_resp_valid = 1'b1;
        mem_resp_data  = 128'h1234;
        for (int c = 0; c <= 12; c++) begin
            if (c > 0) begin
                drive_edge;
                if (c == 12) begin
                    req_valid      = 2'b00;
                    mem_req_ready  = 1'b0;
                    mem_resp_valid = 1'b0;
                end
            end
            sample;
            exp_ready = 2'b00;
            if (c % 3 == 0 && c < 12) exp_ready = ((c / 3) % 2 == 0) ? 2'b01 : 2'b10;
            exp_resp = 2'b00;
            if (c >= 3 && c % 3 == 0) exp_resp = (((c / 3) - 1) % 2 == 0) ? 2'b01 : 2'b10;
            check($sformatf("rr_req_ready_c%0d", c), req_ready, exp_ready);
            check($sformatf("rr_resp_valid_c%0d", c), resp_valid, exp_resp);
            if (c % 3 == 1) check($sformatf("rr_owner_c%0d", c), owner, (c / 3) % 2);
        end

        // ---------------- backpressure on requester 0, write pending on 1
        drive_edge;
        req_valid     = 2'b11;
        req_addr[0]   = 32'h200;
        req_addr[1]   = 32'h40;
        req_write     = 2'b10;
        req_wdata[0]  = '0;
        req_wdata[1]  = DATA_55;
        mem_req_ready = 1'b0;
        sample;
        check("bp_grant", req_ready, 2'b01);

        for (int b = 1; b <= 6; b++) begin
            drive_edge;
            if (b == 1) begin
                req_valid   = 2'b10;
                req_addr[0] = 32'hBAD;
            end
            mem_resp_valid = (b == 3) || (b == 6);
            if (b == 6) mem_req_ready = 1'b1;
            sample;
            check($sformatf("bp_mem_req_valid_%0d", b), mem_req_valid, 1'b1);
            check($sformatf("bp_mem_req_addr_%0d", b), mem_req_addr, 32'h200);
            check($sformatf("bp_mem_req_write_%0d", b), mem_req_write, 1'b0);
            check($sformatf("bp_req_ready_%0d", b), req_ready, 2'b00);
            check($sformatf("bp_resp_valid_%0d", b), resp_valid, 2'b00);
        end

        drive_edge;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b1;
        mem_resp_data  = DATA_CAFE;
        sample;
        check("bp_wait_busy", busy, 1'b1);
        check("bp_wait_mem_req_valid", mem_req_valid, 1'b0);
        check("bp_wait_resp_valid", resp_valid, 2'b00);

        drive_edge;
        mem_resp_valid = 1'b0;
        sample;
        check("bp_resp_valid", resp_valid, 2'b01);
        check("bp_resp_data", resp_data, DATA_CAFE);
        check("simul_req_ready", req_ready, 2'b10);

        // ---------------- write from requester 1
        drive_edge;
        req_valid     = 2'b00;
        mem_req_ready = 1'b1;
        sample;
        check("wr_owner", owner, 1'b1);
        check("wr_mem_req_valid", mem_req_valid, 1'b1);
        check("wr_mem_req_addr", mem_req_addr, 32'h40);
        check("wr_mem_req_write", mem_req_write, 1'b1);
        check("wr_mem_req_wdata", mem_req_wdata, DATA_55);

        drive_edge;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b1;
        mem_resp_data  = DATA_ACK;
        sample;
        check("wr_wait_busy", busy, 1'b1);

        drive_edge;
        mem_resp_valid = 1'b0;
        sample;
        check("wr_resp_valid", resp_valid, 2'b10);
        check("wr_busy_done", busy, 1'b0);

        // ---------------- spurious memory response in IDLE
        drive_edge;
        mem_resp_valid = 1'b1;
        sample;
        check("sp_idle_resp_valid_a", resp_valid, 2'b00);

        drive_edge;
        mem_resp_valid = 1'b0;
        sample;
        check("sp_idle_resp_valid_b", resp_valid, 2'b00);
        check("sp_idle_busy", busy, 1'b0);
        check("sp_idle_mem_req_valid", mem_req_valid, 1'b0);

        // ---------------- reset in the middle of WAIT
        drive_edge;
        req_valid     = 2'b01;
        req_addr[0]   = 32'h300;
        req_write     = 2'b00;
        req_wdata[0]  = DATA_77;
        mem_req_ready = 1'b1;
        sample;
        check("mr_grant", req_ready, 2'b01);

        drive_edge;
        req_valid = 2'b00;
        sample;
        check("mr_issue", mem_req_valid, 1'b1);
        check("mr_issue_wdata", mem_req_wdata, DATA_77);

        drive_edge;
        mem_req_ready = 1'b0;
        rst_n         = 1'b0;
        sample;
        check("mr_wait_busy", busy, 1'b1);

        drive_edge;
        rst_n          = 1'b1;
        mem_resp_valid = 1'b1;
        sample;
        check("mr_rst_busy", busy, 1'b0);
        check("mr_rst_mem_req_valid", mem_req_valid, 1'b0);
        check("mr_rst_resp_valid", resp_valid, 2'b00);
        check("mr_rst_owner", owner, 1'b0);
        check("mr_rst_mem_req_addr", mem_req_addr, 32'h0);
        check("mr_rst_mem_req_wdata", mem_req_wdata, 128'h0);
        check("mr_rst_resp_data", resp_data, 128'h0);

        drive_edge;
        mem_resp_valid = 1'b0;
        req_valid      = 2'b11;
        sample;
        check("mr_late_resp_valid", resp_valid, 2'b00);
        check("mr_next_grant", req_ready, 2'b01);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
